// File: rtl/mult_ctrl_fsm.sv
// Sequencer for the 8x8 multiplier built from four 4x4 partial products accumulated over four cycles.
// Optional build macro MULT_CTRL_ERR_EN adds an ERR state entered on start while busy.
module mult_ctrl_fsm #(
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       sclr_n,
  output logic       clk_ena,
  output logic       done,
  output logic [2:0] state_out,
  output logic       err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LSB  = 3'd2;
  localparam logic [2:0] S_MID  = 3'd3;
  localparam logic [2:0] S_MSB  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    state_d = S_IDLE;
    count_d = 2'd0;
    case (state_q)
      S_IDLE: state_d = start ? S_CLR : S_IDLE;
      S_CLR:  state_d = S_LSB;
      S_LSB: begin
        state_d = S_MID;
        count_d = count_q + 2'd1;
      end
      S_MID: begin
        state_d = (count_q == 2'd1) ? S_MID : S_MSB;
        count_d = count_q + 2'd1;
      end
      // count wraps 3->0 here and nowhere else
      S_MSB: begin
        state_d = S_DONE;
        count_d = count_q + 2'd1;
      end
      S_DONE: state_d = (start && AUTO_RESTART) ? S_CLR : S_IDLE;
`ifdef MULT_CTRL_ERR_EN
      S_ERR:  state_d = start ? S_ERR : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef MULT_CTRL_ERR_EN
    if (start && (state_q == S_LSB || state_q == S_MID || state_q == S_MSB)) begin
      state_d = S_ERR;
      count_d = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore decode; in MID the mux select equals the count (01, then 10)
  always_comb begin
    input_sel = 2'b00;
    shift_sel = 2'b00;
    sclr_n    = 1'b1;
    clk_ena   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_CLR: begin
        clk_ena = 1'b1;
        sclr_n  = 1'b0;
      end
      S_LSB: clk_ena = 1'b1;
      S_MID: begin
        clk_ena   = 1'b1;
        input_sel = count_q;
        shift_sel = 2'b01;
      end
      S_MSB: begin
        clk_ena   = 1'b1;
        input_sel = 2'b11;
        shift_sel = 2'b10;
      end
      S_DONE: done = 1'b1;
`ifdef MULT_CTRL_ERR_EN
      S_ERR:  err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Scoreboard bench: a behavioural accumulator datapath driven by the sequencer, products checked against a*b.
`timescale 1ns/1ps
module tb_mult_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n, start, start0;
  logic [1:0] input_sel, shift_sel, input_sel0, shift_sel0;
  logic sclr_n, clk_ena, done, err, sclr_n0, clk_ena0, done0, err0;
  logic [2:0] state_out, state_out0;
  logic [7:0] a, b;
  logic [15:0] acc;
  logic [3:0] nib_a, nib_b;
  logic [7:0] pp;
  logic [15:0] pp_sh;

  typedef struct { logic [15:0] prod; int done_cyc; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, ld_idx = 0, clr_cnt = 0;
  int SELTAB[4] = '{0, 5, 9, 14};
  int STTAB[4]  = '{2, 3, 3, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_ctrl_fsm #(.AUTO_RESTART(1'b1)) u_dut (
    .clk(clk), .reset_n(rst_n), .start(start), .input_sel(input_sel), .shift_sel(shift_sel),
    .sclr_n(sclr_n), .clk_ena(clk_ena), .done(done), .state_out(state_out), .err(err));

  mult_ctrl_fsm #(.AUTO_RESTART(1'b0)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .start(start0), .input_sel(input_sel0), .shift_sel(shift_sel0),
    .sclr_n(sclr_n0), .clk_ena(clk_ena0), .done(done0), .state_out(state_out0), .err(err0));

  always_comb begin
    nib_a = input_sel[0] ? a[7:4] : a[3:0];
    nib_b = input_sel[1] ? b[7:4] : b[3:0];
    pp    = {4'h0, nib_a} * {4'h0, nib_b};
    case (shift_sel)
      2'b00:   pp_sh = {8'h00, pp};
      2'b01:   pp_sh = {4'h0, pp, 4'h0};
      2'b10:   pp_sh = {pp, 8'h00};
      default: pp_sh = 16'h0;
    endcase
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= 16'h0;
    else if (clk_ena) acc <= !sclr_n ? 16'h0 : acc + pp_sh;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // monitor: per-load mux/shift order, and product/timing at every done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      ld_idx  = 0;
      clr_cnt = 0;
    end else begin
      if (!sclr_n) begin
        chk("sclr_only_in_clr", state_out, 1);
        chk("sclr_with_ena", clk_ena, 1);
        clr_cnt++;
        ld_idx = 0;
      end else if (clk_ena) begin
        if (ld_idx < 4) begin
          chk("load_sel_shift", {input_sel, shift_sel}, SELTAB[ld_idx]);
          chk("load_state", state_out, STTAB[ld_idx]);
        end else chk("extra_load", ld_idx, 3);
        ld_idx++;
      end
      if (done) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("product", acc, e.prod);
          chk("done_cycle", cyc, e.done_cyc);
          chk("clr_count", clr_cnt, 1);
          chk("load_count", ld_idx, 4);
          chk("err_low", err, 0);
        end
        clr_cnt = 0;
      end
    end
  end

  task automatic push_op();
    exp_t e;
    e.prod = {8'h00, a} * {8'h00, b};
    e.done_cyc = cyc + 6;
    exp_q.push_back(e);
  endtask

  task automatic op_pulse(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1 a = x; b = y; start = 1'b1; push_op();
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL wait_done: got no done expected done within 12 cycles"); end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_state"}, state_out, 0);
    chk({tag, "_sel"}, input_sel, 0);
    chk({tag, "_shift"}, shift_sel, 0);
    chk({tag, "_sclr_n"}, sclr_n, 1);
    chk({tag, "_clk_ena"}, clk_ena, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    bit ok;
    int s0, c1, c2;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; a = 8'h0; b = 8'h0;
    #1 chk_reset_outs("reset");
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;

    // directed corners then random products
    op_pulse(8'hFF, 8'hFF);
    op_pulse(8'h12, 8'h34);
    op_pulse(8'h00, 8'hA5);
    for (int i = 0; i < 6; i++) op_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();

    // start during MID
    @(posedge clk); #1 a = 8'h5A; b = 8'hC3; start = 1'b1;
`ifndef MULT_CTRL_ERR_EN
    push_op();
`endif
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
`ifdef MULT_CTRL_ERR_EN
    chk("err_state", state_out, 6);
    chk("err_flag", err, 1);
    chk("err_clk_ena", clk_ena, 0);
    @(posedge clk); #1;
    chk("err_exit_state", state_out, 0);
    chk("err_exit_flag", err, 0);
`else
    chk("busy_start_err", err, 0);
    chk("busy_start_state", state_out, 3);
`endif
    repeat (6) @(posedge clk);
    drain();

    // asynchronous reset in MID at count=2
    @(posedge clk); #1 a = 8'h77; b = 8'h99; start = 1'b1; push_op();
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_reset_state", state_out, 3);
    chk("pre_reset_sel", input_sel, 2);
    rst_n = 1'b0;
    #1 chk_reset_outs("abort");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("no_self_restart", state_out, 0);
    op_pulse(8'hE7, 8'h3C);
    drain();

    // start held, auto-restart: three back-to-back products
    @(posedge clk); #1 a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); start = 1'b1; push_op();
    for (int i = 0; i < 2; i++) begin
      wait_done(ok);
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      push_op();
    end
    wait_done(ok);
    start = 1'b0;
    drain();

    // AUTO_RESTART=0 passes through IDLE between operations
    @(posedge clk); #1 start0 = 1'b1; s0 = cyc;
    c1 = 0; c2 = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done0) begin c1 = cyc; break; end end
    chk("nr_first_done", c1, s0 + 6);
    @(negedge clk); chk("nr_idle_between", state_out0, 0);
    @(negedge clk); chk("nr_clr_after_idle", state_out0, 1);
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done0) begin c2 = cyc; break; end end
    chk("nr_period", c2 - c1, 7);
    start0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
